// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the set-associative tree-PLRU replacer.
// Node k has children 2k+1 (lower half) and 2k+2 (upper half); root is node 0.
package plru_pkg;

    typedef enum logic [0:0] {
        PLRU_IDLE,
        PLRU_FLUSH
    } plru_fsm_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int node_parent(input int k);
        return (k - 1) / 2;
    endfunction

    function automatic int node_child(input int k, input int upper);
        return 2 * k + 1 + upper;
    endfunction

    // Node visited at depth 'level' on the root-to-leaf path of 'way'.
    function automatic int path_node(input int way, input int level, input int way_w);
        return (1 << level) - 1 + (way >> (way_w - level));
    endfunction

endpackage

// File: rtl/plru_tree_walk.sv
// Purpose: one PLRU tree; walks to the victim (steering around fully locked subtrees) and applies a touch.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
module plru_tree_walk
    import plru_pkg::*;
#(
    parameter int WAYS = 8
) (
    input  logic [WAYS-2:0]          tree_i,
    input  logic [$clog2(WAYS)-1:0]  touch_way_i,
    input  logic [WAYS-1:0]          lock_mask_i,
    output logic [$clog2(WAYS)-1:0]  victim_way_o,
    output logic [WAYS-2:0]          tree_o
);

    localparam int WAY_W = $clog2(WAYS);

    always_comb begin : walk
        int   node;
        int   base;
        int   half;
        logic lo_lk;
        logic hi_lk;
        logic dir;
        node  = 0;
        base  = 0;
        half  = 0;
        lo_lk = 1'b0;
        hi_lk = 1'b0;
        dir   = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            half  = WAYS >> (l + 1);
            lo_lk = 1'b1;
            hi_lk = 1'b1;
            dir   = 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                if (w >= base && w < base + half)
                    lo_lk = lo_lk & lock_mask_i[w];
                if (w >= base + half && w < base + 2 * half)
                    hi_lk = hi_lk & lock_mask_i[w];
            end
            for (int k = 0; k < WAYS - 1; k++)
                if (k == node) dir = tree_i[k];
            // A subtree with every way pinned can never supply a victim.
            if (lo_lk && !hi_lk)
                dir = 1'b1;
            else if (hi_lk && !lo_lk)
                dir = 1'b0;
            node = node_child(node, int'(dir));
            base = base + (dir ? half : 0);
        end
        victim_way_o = WAY_W'(base);
    end

    always_comb begin : touch
        int w;
        w      = int'(touch_way_i);
        tree_o = tree_i;
        for (int l = 0; l < WAY_W; l++)
            for (int k = 0; k < WAYS - 1; k++)
                if (k == path_node(w, l, WAY_W))
                    tree_o[k] = (((w >> (WAY_W - 1 - l)) & 1) == 0);
    end

endmodule

// File: rtl/plru_set_replacer.sv
// Purpose: SETS tree-PLRU trees; touch on hit, registered victim per request; optional PLRU_LOCK_EN way pinning.
// Latency: victim one cycle after accept; flush takes SETS cycles. Backpressure: ready_o=0 while flushing, inputs dropped.
module plru_set_replacer
    import plru_pkg::*;
#(
    parameter  int SETS  = 16,
    parameter  int WAYS  = 8,
    localparam int SET_W = clog2_min1(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             touch_valid_i,
    input  logic [SET_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             victim_req_i,
    input  logic [SET_W-1:0] victim_set_i,
    input  logic [WAYS-1:0]  valid_mask_i,
    output logic             victim_valid_o,
    output logic [WAY_W-1:0] victim_way_o,
    input  logic             flush_i,
`ifdef PLRU_LOCK_EN
    input  logic [WAYS-1:0]  lock_mask_i,
    output logic             victim_none_o,
`endif
    output logic             ready_o
);

    logic [WAYS-2:0]  tree_q [SETS];
    plru_fsm_e        state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             vld_q;
    logic [WAY_W-1:0] way_q;

    logic [WAYS-1:0]  lock;
    logic [SET_W-1:0] t_set, v_set;
    logic             acc_touch, acc_req;
    logic [WAYS-2:0]  t_upd, v_upd, victim_tree, pmask;
    logic [WAY_W-1:0] walk_way, touch_walk_way, victim_c, inv_way;
    logic             inv_found, none_c;

`ifdef PLRU_LOCK_EN
    assign lock = lock_mask_i;
`else
    assign lock = '0;
`endif

    assign t_set     = (SETS == 1) ? '0 : touch_set_i;
    assign v_set     = (SETS == 1) ? '0 : victim_set_i;
    assign ready_o   = (state_q == PLRU_IDLE);
    assign acc_touch = touch_valid_i & ready_o & ~flush_i;
    assign acc_req   = victim_req_i  & ready_o & ~flush_i;

    plru_tree_walk #(.WAYS(WAYS)) u_touch (
        .tree_i       (tree_q[t_set]),
        .touch_way_i  (touch_way_i),
        .lock_mask_i  (lock),
        .victim_way_o (touch_walk_way),
        .tree_o       (t_upd)
    );

    plru_tree_walk #(.WAYS(WAYS)) u_victim (
        .tree_i       (tree_q[v_set]),
        .touch_way_i  (victim_c),
        .lock_mask_i  (lock),
        .victim_way_o (walk_way),
        .tree_o       (v_upd)
    );

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mask_i[w] && !lock[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        none_c   = &lock;
        victim_c = inv_found ? inv_way : walk_way;
    end

    // Same-set touch and allocation: victim path bits override the touched tree.
    always_comb begin
        pmask = '0;
        for (int l = 0; l < WAY_W; l++)
            for (int k = 0; k < WAYS - 1; k++)
                if (k == path_node(int'(victim_c), l, WAY_W))
                    pmask[k] = 1'b1;
        victim_tree = v_upd;
        if (acc_touch && (t_set == v_set))
            victim_tree = (t_upd & ~pmask) | (v_upd & pmask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PLRU_IDLE: begin
                if (flush_i) begin
                    state_d = PLRU_FLUSH;
                    cnt_d   = '0;
                end
            end
            PLRU_FLUSH: begin
                if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = PLRU_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = PLRU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PLRU_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            way_q   <= '0;
            for (int s = 0; s < SETS; s++)
                tree_q[s] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= acc_req;
            if (acc_req)
                way_q <= none_c ? '0 : victim_c;
            if (state_q == PLRU_FLUSH) begin
                tree_q[cnt_q] <= '0;
            end else begin
                if (acc_touch)
                    tree_q[t_set] <= t_upd;
                if (acc_req && !none_c)
                    tree_q[v_set] <= victim_tree;
            end
        end
    end

`ifdef PLRU_LOCK_EN
    logic none_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            none_q <= 1'b0;
        else
            none_q <= acc_req & none_c;
    end

    assign victim_none_o = none_q;
`endif

    assign victim_valid_o = vld_q;
    assign victim_way_o   = way_q;

endmodule

// File: tb/tb_plru_set_replacer.sv
// Scoreboard bench for plru_set_replacer: directed scenarios plus random traffic against a tree-PLRU model.
module tb_plru_set_replacer;

    localparam int SETS = 16;
    localparam int WAYS = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       touch_valid_i;
    logic [3:0] touch_set_i;
    logic [2:0] touch_way_i;
    logic       victim_req_i;
    logic [3:0] victim_set_i;
    logic [7:0] valid_mask_i;
    logic       victim_valid_o;
    logic [2:0] victim_way_o;
    logic       flush_i;
    logic       ready_o;
    logic [7:0] lock_mask_i;
    logic       victim_none_o;

    plru_set_replacer #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .touch_valid_i  (touch_valid_i),
        .touch_set_i    (touch_set_i),
        .touch_way_i    (touch_way_i),
        .victim_req_i   (victim_req_i),
        .victim_set_i   (victim_set_i),
        .valid_mask_i   (valid_mask_i),
        .victim_valid_o (victim_valid_o),
        .victim_way_o   (victim_way_o),
        .flush_i        (flush_i),
`ifdef PLRU_LOCK_EN
        .lock_mask_i    (lock_mask_i),
        .victim_none_o  (victim_none_o),
`endif
        .ready_o        (ready_o)
    );

`ifndef PLRU_LOCK_EN
    assign victim_none_o = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int exp_way_q[$];
    bit exp_none_q[$];
    bit mtree [SETS][WAYS-1];
    int mflush   = 0;
    bit prev_req = 0;

    // ---------------- reference model ----------------
    function automatic bit all_locked(logic [7:0] lk, int lo, int n);
        for (int i = lo; i < lo + n; i++)
            if (!lk[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_walk(int s, logic [7:0] lk);
        int node = 0, base = 0, size = WAYS, half;
        bit up;
        while (size > 1) begin
            half = size / 2;
            up   = mtree[s][node];
            if (all_locked(lk, base, half) && !all_locked(lk, base + half, half)) up = 1;
            else if (all_locked(lk, base + half, half) && !all_locked(lk, base, half)) up = 0;
            node = 2 * node + 1 + int'(up);
            if (up) base += half;
            size = half;
        end
        return base;
    endfunction

    task automatic model_touch(int s, int w);
        int node = 0, base = 0, size = WAYS, half;
        bit up;
        while (size > 1) begin
            half = size / 2;
            up   = (w >= base + half);
            mtree[s][node] = !up;
            node = 2 * node + 1 + int'(up);
            if (up) base += half;
            size = half;
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int k = 0; k < WAYS - 1; k++)
                mtree[s][k] = 1'b0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(bit tv, int ts, int tw, bit rq, int vs, logic [7:0] mask, logic [7:0] lk, bit fl);
        int  v;
        bit  none;
        checks++;
        if (ready_o !== (mflush == 0)) begin
            errors++;
            $display("FAIL ready got=%b exp=%b t=%0t", ready_o, (mflush == 0), $time);
        end
        if (prev_req) begin
            checks++;
            if (victim_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL latency victim_valid got=%b exp=1 t=%0t", victim_valid_o, $time);
            end
        end
`ifndef PLRU_LOCK_EN
        lk = 8'h00;
`endif
        touch_valid_i = tv;
        touch_set_i   = 4'(ts);
        touch_way_i   = 3'(tw);
        victim_req_i  = rq;
        victim_set_i  = 4'(vs);
        valid_mask_i  = mask;
        lock_mask_i   = lk;
        flush_i       = fl;
        prev_req      = 0;
        if (mflush == 0) begin
            if (fl) begin
                mflush = SETS;
                model_clear();
            end else begin
                v    = -1;
                none = 0;
                for (int w = 0; w < WAYS; w++)
                    if (v < 0 && !mask[w] && !lk[w]) v = w;
                if (v < 0) begin
                    if (all_locked(lk, 0, WAYS)) none = 1;
                    else v = model_walk(vs, lk);
                end
                if (tv) model_touch(ts, tw);
                if (rq) begin
                    exp_way_q.push_back(none ? 0 : v);
                    exp_none_q.push_back(none);
                    prev_req = 1;
                    if (!none) model_touch(vs, v);
                end
            end
        end else begin
            mflush--;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 8'hFF, 8'h00, 0);
    endtask

    task automatic req(int vs, logic [7:0] mask);
        cycle(0, 0, 0, 1, vs, mask, 8'h00, 0);
    endtask

    task automatic touch(int ts, int tw);
        cycle(1, ts, tw, 0, 0, 8'hFF, 8'h00, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || victim_valid_o !== 1'b0 || victim_way_o !== 3'd0 || victim_none_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ready=%b vld=%b way=%0d none=%b exp 1/0/0/0",
                     ready_o, victim_valid_o, victim_way_o, victim_none_o);
        end
        model_clear();
        mflush   = 0;
        prev_req = 0;
        exp_way_q.delete();
        exp_none_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        int  ew;
        bit  en;
        forever begin
            @(negedge clk_i);
            if (!rst_i && victim_valid_o === 1'b1) begin
                checks++;
                if (exp_way_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_victim way=%0d with nothing queued t=%0t", victim_way_o, $time);
                end else begin
                    ew = exp_way_q.pop_front();
                    en = exp_none_q.pop_front();
                    if (victim_way_o !== 3'(ew) || victim_none_o !== en) begin
                        errors++;
                        $display("FAIL victim got way=%0d none=%b exp way=%0d none=%b t=%0t",
                                 victim_way_o, victim_none_o, ew, en, $time);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ts, vs;
        logic [7:0] mask, lk;
        rst_i         = 1'b1;
        touch_valid_i = 1'b0;
        touch_set_i   = '0;
        touch_way_i   = '0;
        victim_req_i  = 1'b0;
        victim_set_i  = '0;
        valid_mask_i  = 8'hFF;
        lock_mask_i   = 8'h00;
        flush_i       = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // fresh tree: way 0, then way 4
        req(3, 8'hFF);
        req(3, 8'hFF);
        // touch 0..3 in set 5 -> way 4; untouched set -> way 0
        for (int w = 0; w < 4; w++) touch(5, w);
        req(5, 8'hFF);
        req(9, 8'hFF);
        // invalid way wins over tree
        req(2, 8'b1111_0111);
        req(2, 8'hFF);
        // same-cycle touch and request to one set
        cycle(1, 1, 0, 1, 1, 8'hFF, 8'h00, 0);
        req(1, 8'hFF);
        // same-cycle touch and request to different sets
        cycle(1, 6, 7, 1, 7, 8'hFF, 8'h00, 0);
        req(6, 8'hFF);

        // fill, flush, requests during flush dropped
        for (int s = 0; s < SETS; s++) touch(s, s % WAYS);
        cycle(0, 0, 0, 1, 4, 8'hFF, 8'h00, 1);
        for (int i = 0; i < SETS; i++) cycle(1, i, 3, 1, i, 8'hFF, 8'h00, (i == 3));
        req(11, 8'hFF);
        req(0, 8'hFF);

        // reset in the middle of a flush
        cycle(0, 0, 0, 0, 0, 8'hFF, 8'h00, 1);
        repeat (5) idle();
        do_reset();
        req(8, 8'hFF);

`ifdef PLRU_LOCK_EN
        do_reset();
        cycle(0, 0, 0, 1, 2, 8'hFF, 8'h0F, 0);
        cycle(0, 0, 0, 1, 3, 8'hFF, 8'hFF, 0);
        req(3, 8'hFF);
        cycle(0, 0, 0, 1, 3, 8'h00, 8'h01, 0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (mflush > 0 && mflush < SETS && $urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                vs   = $urandom_range(0, 3) == 0 ? $urandom_range(0, SETS - 1) : $urandom_range(0, 2);
                ts   = $urandom_range(0, 1) == 0 ? vs : $urandom_range(0, 2);
                mask = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
                lk   = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'h00;
                if ($urandom_range(0, 15) == 0) lk = 8'hFF;
                cycle(1'($urandom_range(0, 1)), ts, $urandom_range(0, WAYS - 1),
                      1'($urandom_range(0, 1)), vs, mask, lk, ($urandom_range(0, 149) == 0));
            end
        end

        repeat (3) idle();
        checks++;
        if (exp_way_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", exp_way_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
